// File: rtl/rr_mux_select_if.sv
// Request/grant bundle between the sources and the round-robin mux select sequencer.
// The master side raises requests and release strobes; the slave side drives select/grant.
interface rr_mux_select_if #(
  parameter int S = 2
);
  localparam int N = 1 << S;

  logic [N-1:0] req;
  logic         done;
  logic [S-1:0] sel;
  logic [N-1:0] grant;
  logic         valid;

  modport master (
    output req,
    output done,
    input  sel,
    input  grant,
    input  valid
  );

  modport slave (
    input  req,
    input  done,
    output sel,
    output grant,
    output valid
  );
endinterface

// File: rtl/rr_mux_select.sv
// Round-robin select sequencer driving the select bus of a downstream recursive mux.
// A grant is held until done or request drop, then one idle cycle precedes the next grant.
module rr_mux_select #(
  parameter int S = 2
) (
  input  logic           clk,
  input  logic           rst,
  rr_mux_select_if.slave bus
);
  localparam int N = 1 << S;

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic [S-1:0] ptr_q;
  logic [S-1:0] ptr_d;
  logic [S-1:0] sel_q;
  logic [S-1:0] sel_d;
  logic [N-1:0] grant_q;
  logic [N-1:0] grant_d;
  logic         valid_q;
  logic         valid_d;

  logic         found;
  logic [S-1:0] win;
  logic [S-1:0] idx;
  logic         release_now;

  // Circular search starting at ptr; index arithmetic wraps at S bits.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr_q + S'(k);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign release_now = bus.done || !bus.req[sel_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        valid_d = 1'b0;
        if (found) begin
          sel_d   = win;
          grant_d = N'(1) << win;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // sel is kept on release so the mux input never moves while valid drops.
        if (release_now) begin
          ptr_d   = sel_q + S'(1);
          grant_d = '0;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
    end
  end

  assign bus.sel   = sel_q;
  assign bus.grant = grant_q;
  assign bus.valid = valid_q;
endmodule

// File: tb/tb_rr_mux_select.sv
// Directed testbench for rr_mux_select with S=2 (four sources).
// Each scenario task drives inputs on the falling edge and checks outputs there.
module tb_rr_mux_select;
  localparam int S = 2;

  logic clk;
  logic rst;
  int   tests;
  int   failed;
  bit   mon_en;

  rr_mux_select_if #(.S(S)) bus ();

  rr_mux_select #(.S(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [3:0] exp_g;
    if (mon_en) begin
      exp_g = 4'b0001 << bus.sel;
      tests++;
      if (!$onehot0(bus.grant)) begin
        failed++;
        $display("FAIL inv_onehot grant=%b required one-hot or zero", bus.grant);
      end
      tests++;
      if (bus.valid !== (|bus.grant)) begin
        failed++;
        $display("FAIL inv_valid valid=%b required %b", bus.valid, |bus.grant);
      end
      if (bus.valid) begin
        tests++;
        if (bus.grant !== exp_g) begin
          failed++;
          $display("FAIL inv_grant_sel grant=%b required %b", bus.grant, exp_g);
        end
      end
    end
  end

  task automatic expect_out(string name, logic [1:0] s, logic [3:0] g, logic v);
    tests++;
    if (bus.sel !== s || bus.grant !== g || bus.valid !== v) begin
      failed++;
      $display("FAIL %s sel=%0d grant=%b valid=%b required sel=%0d grant=%b valid=%b",
               name, bus.sel, bus.grant, bus.valid, s, g, v);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = 4'b0000;
    bus.done = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 4'b1111;
    bus.done = 1'b1;
    step();
    expect_out("reset_c1", 2'd0, 4'b0000, 1'b0);
    step();
    expect_out("reset_c2", 2'd0, 4'b0000, 1'b0);
    rst = 1'b0;
    bus.done = 1'b0;
    step();
    expect_out("reset_first_grant", 2'd0, 4'b0001, 1'b1);
  endtask

  task automatic test_single();
    do_reset();
    bus.req = 4'b0100;
    step();
    expect_out("single_grant", 2'd2, 4'b0100, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("single_hold", 2'd2, 4'b0100, 1'b1);
    end
    bus.done = 1'b1;
    step();
    expect_out("single_release", 2'd2, 4'b0000, 1'b0);
    bus.done = 1'b0;
  endtask

  task automatic test_wrap();
    bus.req = 4'b0011;
    step();
    expect_out("wrap_sel0", 2'd0, 4'b0001, 1'b1);
    bus.done = 1'b1;
    step();
    expect_out("wrap_release", 2'd0, 4'b0000, 1'b0);
    bus.done = 1'b0;
    step();
    expect_out("wrap_sel1", 2'd1, 4'b0010, 1'b1);
    bus.done = 1'b1;
    bus.req = 4'b0000;
    step();
    expect_out("wrap_release2", 2'd1, 4'b0000, 1'b0);
    bus.done = 1'b0;
    bus.req = 4'b0000;
    bus.done = 1'b1;
    step();
    expect_out("done_in_idle", 2'd1, 4'b0000, 1'b0);
    bus.done = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0] s;
    logic [3:0] g;
    do_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      s = 2'(i % 4);
      g = 4'b0001 << s;
      step();
      expect_out("rr_grant", s, g, 1'b1);
      step();
      expect_out("rr_hold", s, g, 1'b1);
      bus.done = 1'b1;
      step();
      expect_out("rr_idle", s, 4'b0000, 1'b0);
      bus.done = 1'b0;
    end
    bus.req = 4'b0000;
    step();
  endtask

  task automatic test_drop_and_reset();
    do_reset();
    bus.req = 4'b0010;
    step();
    expect_out("drop_grant", 2'd1, 4'b0010, 1'b1);
    bus.req = 4'b0000;
    step();
    expect_out("drop_release", 2'd1, 4'b0000, 1'b0);
    step();
    expect_out("drop_stay_idle", 2'd1, 4'b0000, 1'b0);
    bus.req = 4'b1011;
    step();
    expect_out("drop_ptr2_sel3", 2'd3, 4'b1000, 1'b1);
    rst = 1'b1;
    step();
    expect_out("midgrant_reset", 2'd0, 4'b0000, 1'b0);
    rst = 1'b0;
    bus.req = 4'b1010;
    step();
    expect_out("after_reset_sel1", 2'd1, 4'b0010, 1'b1);
    bus.done = 1'b1;
    bus.req = 4'b1111;
    step();
    expect_out("done_with_new_req", 2'd1, 4'b0000, 1'b0);
    bus.done = 1'b0;
    step();
    expect_out("regrant_from_ptr2", 2'd2, 4'b0100, 1'b1);
  endtask

  initial begin
    tests = 0;
    failed = 0;
    mon_en = 1'b0;
    rst = 1'b1;
    bus.req = 4'b0000;
    bus.done = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_drop_and_reset();
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
